// File: rtl/iic_eeprom_slave.sv
// rtl/iic_eeprom_slave.sv - clock-sampled 24Cxx-style I2C EEPROM slave model
// Page writes are buffered and committed on STOP, followed by an internal write cycle.
module iic_eeprom_slave #(
   parameter logic [6:0] DEV_ADDR  = 7'b1010000,
   parameter int         MEM_DEPTH = 256,
   parameter int         PAGE_SIZE = 8,
   parameter int         TWR_CYC   = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_m2s,
   output logic       sda_s2m,
   output logic       busy,
   input  logic       bd_we,
   input  logic [7:0] bd_addr,
   input  logic [7:0] bd_wdata
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int PW = $clog2(PAGE_SIZE);
   localparam int CW = $clog2(TWR_CYC + 1);
   localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] DEVADDR  = 4'd1;
   localparam logic [3:0] DEVACK   = 4'd2;
   localparam logic [3:0] WADDR    = 4'd3;
   localparam logic [3:0] WADDRACK = 4'd4;
   localparam logic [3:0] WDATA    = 4'd5;
   localparam logic [3:0] WDATAACK = 4'd6;
   localparam logic [3:0] RDATA    = 4'd7;
   localparam logic [3:0] RDACK    = 4'd8;

   logic [2:0]           scl_q;
   logic [2:0]           sda_q;
   logic                 scl_rise;
   logic                 scl_fall;
   logic                 start_det;
   logic                 stop_det;
   logic [3:0]           state;
   logic [3:0]           bit_cnt;
   logic [7:0]           shreg;
   logic [7:0]           byte_in;
   logic                 ack_ok;
   logic [AW-1:0]        ptr;
   logic [AW-1:0]        ptr_inc;
   logic [AW-1:0]        ptr_page_inc;
   logic [7:0]           mem [MEM_DEPTH];
   logic [7:0]           pbuf [PAGE_SIZE];
   logic [PAGE_SIZE-1:0] pvalid;
   logic                 have_data;
   logic                 do_commit;
   logic [CW-1:0]        twr_cnt;

   // Index 1 is the synchronized level, index 2 the previous one for edge detection.
   assign scl_rise  = scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] & scl_q[2];
   assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
   assign byte_in   = {shreg[6:0], sda_q[1]};

   assign ptr_inc      = ptr + AW'(1);
   assign ptr_page_inc = (ptr & ~PMASK) | (ptr_inc & PMASK);

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_q     <= 3'b111;
         sda_q     <= 3'b111;
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         ack_ok    <= 1'b0;
         ptr       <= '0;
         sda_s2m   <= 1'b1;
         pvalid    <= '0;
         have_data <= 1'b0;
         do_commit <= 1'b0;
         busy      <= 1'b0;
         twr_cnt   <= '0;
      end else begin
         scl_q     <= {scl_q[1:0], scl};
         sda_q     <= {sda_q[1:0], sda_m2s};
         do_commit <= 1'b0;

         if (do_commit) begin
            pvalid  <= '0;
            busy    <= 1'b1;
            twr_cnt <= CW'(TWR_CYC - 1);
         end else if (busy) begin
            if (twr_cnt == '0) busy <= 1'b0;
            else               twr_cnt <= twr_cnt - CW'(1);
         end

         if (start_det) begin
            state     <= DEVADDR;
            bit_cnt   <= 4'd0;
            sda_s2m   <= 1'b1;
            have_data <= 1'b0;
            pvalid    <= '0;
         end else if (stop_det) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            sda_s2m   <= 1'b1;
            have_data <= 1'b0;
            do_commit <= have_data;
            if (!have_data) pvalid <= '0;
         end else begin
            case (state)
               IDLE: ;
               DEVADDR: begin
                  if (scl_rise) begin
                     shreg   <= byte_in;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        state   <= DEVACK;
                        ack_ok  <= (byte_in[7:1] == DEV_ADDR) && !busy;
                     end
                  end
               end
               DEVACK: begin
                  if (scl_fall && ack_ok) sda_s2m <= 1'b0;
                  if (scl_rise) begin
                     bit_cnt <= 4'd0;
                     if (!ack_ok) begin
                        state <= IDLE;
                     end else if (shreg[0]) begin
                        state <= RDATA;
                        shreg <= mem[ptr];
                     end else begin
                        state <= WADDR;
                     end
                  end
               end
               WADDR, WDATA: begin
                  if (scl_fall) sda_s2m <= 1'b1;
                  if (scl_rise) begin
                     shreg   <= byte_in;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        state   <= (state == WADDR) ? WADDRACK : WDATAACK;
                     end
                  end
               end
               WADDRACK: begin
                  if (scl_fall) sda_s2m <= 1'b0;
                  if (scl_rise) begin
                     ptr   <= shreg[AW-1:0];
                     state <= WDATA;
                  end
               end
               WDATAACK: begin
                  // The byte only counts as accepted once the ACK is actually driven.
                  if (scl_fall) begin
                     sda_s2m               <= 1'b0;
                     pbuf[ptr[PW-1:0]]     <= shreg;
                     pvalid[ptr[PW-1:0]]   <= 1'b1;
                     have_data             <= 1'b1;
                  end
                  if (scl_rise) begin
                     ptr   <= ptr_page_inc;
                     state <= WDATA;
                  end
               end
               RDATA: begin
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_s2m <= 1'b1;
                        bit_cnt <= 4'd0;
                        state   <= RDACK;
                     end else begin
                        sda_s2m <= shreg[7];
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end
               RDACK: begin
                  if (scl_rise) begin
                     if (!sda_q[1]) begin
                        ptr   <= ptr_inc;
                        shreg <= mem[ptr_inc];
                        state <= RDATA;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Back-door write is placed last so it wins over a same-cycle commit.
   always_ff @(posedge clk) begin
      if (do_commit) begin
         for (int i = 0; i < PAGE_SIZE; i++) begin
            if (pvalid[i]) mem[(ptr & ~PMASK) | AW'(i)] <= pbuf[i];
         end
      end
      if (bd_we && !busy) mem[bd_addr[AW-1:0]] <= bd_wdata;
   end

endmodule
